// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller feeding one shared seg7 decoder. Each digit gets a
// fixed slot with a blanked guard window; the display value is double-buffered per frame.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned SCAN_DIV         = 50000,
    parameter int unsigned BLANK_GAP        = 16,
    parameter int unsigned DIGIT_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [3:0]              dec_nibble,
    output logic                    seg_blank,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_start,
    output logic                    upd_done
);
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [VAL_W-1:0]      r_display;
    logic [VAL_W-1:0]      r_pending;
    logic                  r_pend_valid;
    logic                  r_lz;
    logic [3:0]            r_dec_nibble;
    logic                  r_seg_blank;
    logic [NUM_DIGITS-1:0] r_dig_sel;
    logic                  r_frame_start;
    logic                  r_upd_done;

    logic                  w_commit;
    logic [VAL_W-1:0]      w_display_n;
    logic                  w_slot_end;
    logic                  w_guard_end;
    logic [IDX_W-1:0]      w_idx_next;
    logic [3:0]            w_nib_cur;
    logic [3:0]            w_nib_next;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] w_sel_on;
    logic [NUM_DIGITS-1:0] w_lz_blank;
    logic                  w_zero_run;

    // The cycle frame_start is high is the only commit point of the display buffer.
    assign w_commit = (r_state == S_GUARD) && (r_idx == '0) && (r_cnt == '0) && enable;

    always_comb begin
        w_display_n = r_display;
        if (w_commit) begin
            if (load) begin
                w_display_n = value_in;
            end else if (r_pend_valid) begin
                w_display_n = r_pending;
            end
        end
    end

    assign w_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_guard_end = (r_cnt == CNT_W'(BLANK_GAP - 1));
    assign w_idx_next  = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    assign w_nib_cur   = w_display_n[{r_idx, 2'b00} +: 4];
    assign w_nib_next  = w_display_n[{w_idx_next, 2'b00} +: 4];
    assign w_onehot    = NUM_DIGITS'(1) << r_idx;
    assign w_sel_on    = (DIGIT_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;

    // Digit k is a leading zero when it and every more significant digit are zero.
    always_comb begin
        w_lz_blank = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run    = w_zero_run && (w_display_n[4*k +: 4] == 4'd0);
            w_lz_blank[k] = (k != 0) && w_zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_display     <= '0;
            r_pending     <= '0;
            r_pend_valid  <= 1'b0;
            r_lz          <= 1'b0;
            r_dec_nibble  <= 4'd0;
            r_seg_blank   <= 1'b1;
            r_dig_sel     <= DIG_OFF;
            r_frame_start <= 1'b0;
            r_upd_done    <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_upd_done    <= w_commit && (load || r_pend_valid);
            r_display     <= w_display_n;

            if (w_commit) begin
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pending    <= value_in;
                r_pend_valid <= 1'b1;
            end

            if (!enable) begin
                r_state      <= S_IDLE;
                r_idx        <= '0;
                r_cnt        <= '0;
                r_dec_nibble <= 4'd0;
                r_seg_blank  <= 1'b1;
                r_dig_sel    <= DIG_OFF;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state       <= S_GUARD;
                        r_idx         <= '0;
                        r_cnt         <= '0;
                        r_lz          <= lz_en;
                        r_frame_start <= 1'b1;
                        r_dec_nibble  <= w_display_n[3:0];
                        r_seg_blank   <= 1'b1;
                        r_dig_sel     <= DIG_OFF;
                    end
                    S_GUARD, S_SHOW: begin
                        if (w_slot_end) begin
                            r_state       <= S_GUARD;
                            r_idx         <= w_idx_next;
                            r_cnt         <= '0;
                            r_lz          <= lz_en;
                            r_frame_start <= (w_idx_next == '0);
                            r_dec_nibble  <= w_nib_next;
                            r_seg_blank   <= 1'b1;
                            r_dig_sel     <= DIG_OFF;
                        end else begin
                            r_cnt        <= r_cnt + CNT_W'(1);
                            r_dec_nibble <= w_nib_cur;
                            if ((r_state == S_GUARD) && w_guard_end) begin
                                r_state     <= S_SHOW;
                                r_dig_sel   <= w_sel_on;
                                r_seg_blank <= r_lz && w_lz_blank[r_idx];
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign dec_nibble  = r_dec_nibble;
    assign seg_blank   = r_seg_blank;
    assign dig_sel     = r_dig_sel;
    assign frame_start = r_frame_start;
    assign upd_done    = r_upd_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic, all checked
// against a frame-time reference model.
module tb_seg7_scan_ctrl;
    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BG    = 2;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] value_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  dec_nibble;
    logic        seg_blank;
    logic [3:0]  dig_sel;
    logic        frame_start;
    logic        upd_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_GAP(BG), .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .value_in(value_in), .load(load),
        .lz_en(lz_en), .dec_nibble(dec_nibble), .seg_blank(seg_blank),
        .dig_sel(dig_sel), .frame_start(frame_start), .upd_done(upd_done)
    );

    // Reference model: position in the frame as a plain cycle count since scan start.
    bit          m_run;
    int          m_t;
    int          slot;
    logic [15:0] m_disp, m_pend;
    bit          m_pv, m_lz;
    logic [3:0]  e_nib, e_dig;
    logic        e_blank, e_fs, e_upd;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_t = 0; m_disp = 0; m_pend = 0; m_pv = 0; m_lz = 0; e_upd = 0;
        end else begin
            e_upd = 0;
            if (m_run && m_t == 0 && enable) begin
                if (load) begin
                    m_disp = value_in; e_upd = 1;
                end else if (m_pv) begin
                    m_disp = m_pend; e_upd = 1;
                end
                m_pv = 0;
            end else if (load) begin
                m_pend = value_in; m_pv = 1;
            end
            if (!enable) m_run = 0;
            else if (!m_run) begin m_run = 1; m_t = 0; end
            else m_t = (m_t + 1) % FRAME;
            if (m_run && (m_t % SD) == 0) m_lz = lz_en;
        end
        if (!m_run) begin
            e_nib = 4'd0; e_blank = 1'b1; e_dig = 4'hF; e_fs = 1'b0;
        end else begin
            slot  = m_t / SD;
            e_nib = 4'((m_disp >> (4 * slot)) & 16'hF);
            e_fs  = (m_t == 0);
            if ((m_t % SD) < BG) begin
                e_dig = 4'hF; e_blank = 1'b1;
            end else begin
                e_dig   = ~(4'(1) << slot);
                e_blank = m_lz && (slot != 0) && ((m_disp >> (4 * slot)) == 16'd0);
            end
        end
    end

    task automatic wait_fs(output bit ok);
        ok = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (frame_start) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1; enable = 0; load = 0; lz_en = 0; value_in = 16'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {4'd0, 1'b1, 4'hF, 1'b0, 1'b0})
            $display("FAIL reset_values got=%h exp=%h", {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {4'd0, 1'b1, 4'hF, 1'b0, 1'b0});
        else n_pass++;
        n_checks++;
        if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {e_nib, e_blank, e_dig, e_fs, e_upd})
            $display("FAIL reset_model got=%h exp=%h", {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {e_nib, e_blank, e_dig, e_fs, e_upd});
        else n_pass++;
    endtask

    task automatic test_scan_sequence();
        int last_fs = -1;
        rst = 0; enable = 1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {e_nib, e_blank, e_dig, e_fs, e_upd})
                $display("FAIL scan_model c=%0d got=%h exp=%h", c, {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {e_nib, e_blank, e_dig, e_fs, e_upd});
            else n_pass++;
            if (c < 2) begin
                n_checks++;
                if (dig_sel !== 4'b1111) $display("FAIL scan_guard c=%0d got=%b exp=1111", c, dig_sel);
                else n_pass++;
            end else if (c < 8) begin
                n_checks++;
                if ({dig_sel, dec_nibble} !== {4'b1110, 4'd0}) $display("FAIL scan_digit0 c=%0d got=%h exp=e0", c, {dig_sel, dec_nibble});
                else n_pass++;
            end
            if (frame_start) begin
                n_checks++;
                if ((last_fs < 0 && c != 0) || (last_fs >= 0 && c - last_fs != FRAME))
                    $display("FAIL frame_period c=%0d got=%0d exp=%0d", c, c - last_fs, FRAME);
                else n_pass++;
                last_fs = c;
            end
        end
    endtask

    task automatic test_load_midframe();
        bit ok;
        bit got_fs = 0;
        logic [15:0] shown = 16'h0;
        int n_upd = 0;
        int upd_at = -1;
        wait_fs(ok);
        n_checks++; if (!ok) $display("FAIL load_wait_fs got=0 exp=1"); else n_pass++;
        repeat (10) @(negedge clk);
        value_in = 16'h1A3F; load = 1;
        @(negedge clk); load = 0;
        for (int c = 0; c < 2 * FRAME && !got_fs; c++) begin
            @(negedge clk);
            if (frame_start) got_fs = 1;
            else if (dig_sel !== 4'hF) begin
                n_checks++;
                if (dec_nibble !== 4'd0) $display("FAIL load_old_value got=%h exp=0", dec_nibble);
                else n_pass++;
            end
        end
        n_checks++; if (!got_fs) $display("FAIL load_next_fs got=0 exp=1"); else n_pass++;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {e_nib, e_blank, e_dig, e_fs, e_upd})
                $display("FAIL load_model c=%0d got=%h exp=%h", c, {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {e_nib, e_blank, e_dig, e_fs, e_upd});
            else n_pass++;
            if (upd_done) begin n_upd++; upd_at = c; end
            for (int k = 0; k < ND; k++) if (dig_sel !== 4'hF && dig_sel[k] == 1'b0) shown[4*k +: 4] = dec_nibble;
        end
        n_checks++; if (shown !== 16'h1A3F) $display("FAIL load_shown got=%h exp=1a3f", shown); else n_pass++;
        n_checks++; if (n_upd != 1 || upd_at != 1) $display("FAIL load_upd_done got=%0d@%0d exp=1@1", n_upd, upd_at); else n_pass++;
    endtask

    task automatic test_leading_zero();
        bit ok;
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        logic [3:0]  exp_blank [2] = '{4'b1100, 4'b1110};
        logic [15:0] shown;
        logic [3:0]  blanks;
        lz_en = 1;
        for (int v = 0; v < 2; v++) begin
            value_in = vals[v]; load = 1;
            @(negedge clk); load = 0;
            wait_fs(ok);
            n_checks++; if (!ok) $display("FAIL lz_wait_fs got=0 exp=1"); else n_pass++;
            shown = 16'hFFFF; blanks = 4'h0;
            for (int c = 1; c <= FRAME; c++) begin
                @(negedge clk);
                n_checks++;
                if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {e_nib, e_blank, e_dig, e_fs, e_upd})
                    $display("FAIL lz_model c=%0d got=%h exp=%h", c, {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {e_nib, e_blank, e_dig, e_fs, e_upd});
                else n_pass++;
                for (int k = 0; k < ND; k++)
                    if (dig_sel !== 4'hF && dig_sel[k] == 1'b0) begin
                        shown[4*k +: 4] = dec_nibble; blanks[k] = seg_blank;
                    end
            end
            n_checks++; if (blanks !== exp_blank[v]) $display("FAIL lz_blank_mask got=%b exp=%b", blanks, exp_blank[v]); else n_pass++;
            n_checks++; if (shown !== vals[v]) $display("FAIL lz_nibbles got=%h exp=%h", shown, vals[v]); else n_pass++;
        end
        lz_en = 0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] shown = 16'h0;
        int n_upd = 0;
        wait_fs(ok);
        n_checks++; if (!ok) $display("FAIL b2b_wait_fs got=0 exp=1"); else n_pass++;
        repeat (4) @(negedge clk);
        value_in = 16'h1111; load = 1;
        @(negedge clk); load = 0;
        repeat (5) @(negedge clk);
        value_in = 16'h2222; load = 1;
        @(negedge clk); load = 0;
        wait_fs(ok);
        n_checks++; if (!ok) $display("FAIL b2b_commit_fs got=0 exp=1"); else n_pass++;
        value_in = 16'h3333; load = 1;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (c == 1) load = 0;
            n_checks++;
            if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {e_nib, e_blank, e_dig, e_fs, e_upd})
                $display("FAIL b2b_model c=%0d got=%h exp=%h", c, {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {e_nib, e_blank, e_dig, e_fs, e_upd});
            else n_pass++;
            if (upd_done) n_upd++;
            for (int k = 0; k < ND; k++) if (dig_sel !== 4'hF && dig_sel[k] == 1'b0) shown[4*k +: 4] = dec_nibble;
        end
        n_checks++; if (shown !== 16'h3333) $display("FAIL b2b_shown got=%h exp=3333", shown); else n_pass++;
        n_checks++; if (n_upd != 1) $display("FAIL b2b_upd_count got=%0d exp=1", n_upd); else n_pass++;
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit found = 0;
        logic [15:0] shown = 16'h0;
        wait_fs(ok);
        n_checks++; if (!ok) $display("FAIL en_wait_fs got=0 exp=1"); else n_pass++;
        repeat (3) @(negedge clk);
        value_in = 16'h4567; load = 1;
        @(negedge clk); load = 0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clk);
            if (dig_sel === 4'b1011) found = 1;
        end
        n_checks++; if (!found) $display("FAIL en_digit2 got=0 exp=1"); else n_pass++;
        repeat (2) @(negedge clk);
        enable = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({dig_sel, seg_blank, frame_start, upd_done} !== {4'hF, 1'b1, 1'b0, 1'b0})
                $display("FAIL en_off c=%0d got=%h exp=f4", c, {dig_sel, seg_blank, frame_start, upd_done});
            else n_pass++;
        end
        enable = 1;
        @(negedge clk);
        n_checks++;
        if ({frame_start, dig_sel} !== {1'b1, 4'hF}) $display("FAIL en_restart got=%h exp=1f", {frame_start, dig_sel});
        else n_pass++;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {e_nib, e_blank, e_dig, e_fs, e_upd})
                $display("FAIL en_model c=%0d got=%h exp=%h", c, {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {e_nib, e_blank, e_dig, e_fs, e_upd});
            else n_pass++;
            if (c == 1) begin
                n_checks++; if (upd_done !== 1'b1) $display("FAIL en_upd_done got=%b exp=1", upd_done); else n_pass++;
            end
            for (int k = 0; k < ND; k++) if (dig_sel !== 4'hF && dig_sel[k] == 1'b0) shown[4*k +: 4] = dec_nibble;
        end
        n_checks++; if (shown !== 16'h4567) $display("FAIL en_shown got=%h exp=4567", shown); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [15:0] shown = 16'hFFFF;
        int n_upd = 0;
        wait_fs(ok);
        n_checks++; if (!ok) $display("FAIL rstm_wait_fs got=0 exp=1"); else n_pass++;
        repeat (5) @(negedge clk);
        value_in = 16'h9999; load = 1;
        @(negedge clk); load = 0; rst = 1;
        @(negedge clk);
        n_checks++;
        if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {4'd0, 1'b1, 4'hF, 1'b0, 1'b0})
            $display("FAIL rstm_values got=%h exp=%h", {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {4'd0, 1'b1, 4'hF, 1'b0, 1'b0});
        else n_pass++;
        rst = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {e_nib, e_blank, e_dig, e_fs, e_upd})
                $display("FAIL rstm_model c=%0d got=%h exp=%h", c, {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {e_nib, e_blank, e_dig, e_fs, e_upd});
            else n_pass++;
            if (upd_done) n_upd++;
            for (int k = 0; k < ND; k++) if (dig_sel !== 4'hF && dig_sel[k] == 1'b0) shown[4*k +: 4] = dec_nibble;
        end
        n_checks++; if (n_upd != 0) $display("FAIL rstm_upd_done got=%0d exp=0", n_upd); else n_pass++;
        n_checks++; if (shown !== 16'h0) $display("FAIL rstm_shown got=%h exp=0000", shown); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_checks++;
            if ({dec_nibble, seg_blank, dig_sel, frame_start, upd_done} !== {e_nib, e_blank, e_dig, e_fs, e_upd})
                $display("FAIL rand_model c=%0d got=%h exp=%h", c, {dec_nibble, seg_blank, dig_sel, frame_start, upd_done}, {e_nib, e_blank, e_dig, e_fs, e_upd});
            else n_pass++;
            rst      = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 99) != 0);
            load     = ($urandom_range(0, 5) == 0);
            value_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 40) == 0) lz_en = ~lz_en;
        end
        rst = 0; load = 0; enable = 1;
    endtask

    initial begin
        rst = 1; enable = 0; load = 0; lz_en = 0; value_in = 16'h0;
        test_reset();
        test_scan_sequence();
        test_load_midframe();
        test_leading_zero();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
